// File: rtl/nios_data_serializer_if.sv
// Command/serial/status bundle between the data PIO, the serializer and the input PIO.
interface nios_data_serializer_if;
  logic [31:0] cmd_word;
  logic        sclk;
  logic        sdo;
  logic        cs_n;
  logic        busy;
  logic        done;
  logic [31:0] status;

  modport master (
    output cmd_word,
    input  sclk, sdo, cs_n, busy, done, status
  );

  modport slave (
    input  cmd_word,
    output sclk, sdo, cs_n, busy, done, status
  );
endinterface

// File: rtl/nios_data_serializer.sv
// Turns toggle-flagged PIO command words into MSB-first 3-wire serial frames
// and reports ack/busy/overrun/frame counts back through a status word.
module nios_data_serializer #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned PAYLOAD_W = 24
) (
  input logic                   clk,
  input logic                   reset,
  nios_data_serializer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, HOLD} state_t;

  localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
  localparam logic [4:0] LAST_MAX   = 5'(PAYLOAD_W - 1);

  state_t               state, state_n;
  logic [7:0]           div_cnt, div_n;
  logic [PAYLOAD_W-1:0] shreg, shreg_n, aligned;
  logic [4:0]           left, left_n, last;
  logic                 tgl_q, new_cmd;
  logic                 sdo_r, sdo_n;
  logic                 done_r, done_n;
  logic                 ack, ack_n;
  logic [7:0]           frames, frames_n;
  logic [7:0]           overruns, overruns_n;
  logic [31:0]          status_r, status_n;
  logic                 unused_rsvd;

  assign unused_rsvd = ^bus.cmd_word[30:29];
  assign new_cmd     = bus.cmd_word[31] ^ tgl_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      div_cnt  <= '0;
      shreg    <= '0;
      left     <= '0;
      tgl_q    <= 1'b0;
      sdo_r    <= 1'b0;
      done_r   <= 1'b0;
      ack      <= 1'b0;
      frames   <= '0;
      overruns <= '0;
      status_r <= '0;
    end else begin
      state    <= state_n;
      div_cnt  <= div_n;
      shreg    <= shreg_n;
      left     <= left_n;
      tgl_q    <= bus.cmd_word[31];
      sdo_r    <= sdo_n;
      done_r   <= done_n;
      ack      <= ack_n;
      frames   <= frames_n;
      overruns <= overruns_n;
      status_r <= status_n;
    end
  end

  always_comb begin
    state_n    = state;
    div_n      = div_cnt;
    shreg_n    = shreg;
    left_n     = left;
    sdo_n      = sdo_r;
    done_n     = 1'b0;
    ack_n      = ack;
    frames_n   = frames;
    overruns_n = overruns;
    // Oversized length fields clamp to a full payload.
    last       = (bus.cmd_word[28:24] > LAST_MAX) ? LAST_MAX : bus.cmd_word[28:24];
    // Left-align the payload so the first bit to send always sits in the MSB.
    aligned    = bus.cmd_word[PAYLOAD_W-1:0] << (LAST_MAX - last);

    unique case (state)
      IDLE: begin
        div_n = '0;
        if (new_cmd) begin
          state_n = LOW;
          div_n   = DIV_RELOAD;
          left_n  = last;
          shreg_n = aligned;
          sdo_n   = aligned[PAYLOAD_W-1];
        end
      end
      LOW: begin
        if (div_cnt == '0) begin
          state_n = HIGH;
          div_n   = DIV_RELOAD;
        end else begin
          div_n = div_cnt - 8'd1;
        end
      end
      HIGH: begin
        if (div_cnt == '0) begin
          div_n = DIV_RELOAD;
          if (left == '0) begin
            state_n = HOLD;
          end else begin
            state_n = LOW;
            left_n  = left - 5'd1;
            shreg_n = shreg << 1;
            sdo_n   = shreg[PAYLOAD_W-2];
          end
        end else begin
          div_n = div_cnt - 8'd1;
        end
      end
      HOLD: begin
        if (div_cnt == '0) begin
          state_n  = IDLE;
          div_n    = '0;
          sdo_n    = 1'b0;
          done_n   = 1'b1;
          ack_n    = ~ack;
          frames_n = frames + 8'd1;
        end else begin
          div_n = div_cnt - 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (new_cmd && (state != IDLE) && (overruns != 8'hFF)) begin
      overruns_n = overruns + 8'd1;
    end
  end

  assign status_n = {ack, (state != IDLE), 14'd0, overruns, frames};

  assign bus.sclk   = (state == HIGH);
  assign bus.cs_n   = (state == IDLE);
  assign bus.busy   = (state != IDLE);
  assign bus.sdo    = sdo_r;
  assign bus.done   = done_r;
  assign bus.status = status_r;

endmodule

// File: tb/tb_nios_data_serializer.sv
// Randomised scoreboard bench: driver predicts frames from command timing, monitor decodes the serial line.
module tb_nios_data_serializer;

  localparam int D = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nios_data_serializer_if bus0();
  nios_data_serializer_if bus1();

  nios_data_serializer #(.CLK_DIV(D), .PAYLOAD_W(24)) dut (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  nios_data_serializer #(.CLK_DIV(1), .PAYLOAD_W(24)) dut_min (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  typedef struct {
    int         t;
    int         n;
    logic [23:0] p;
  } frame_t;

  frame_t exp_q[$];
  int     ovr_q[$];
  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  int     model_free = 0;
  logic   model_tgl = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
    end
  endfunction

  function automatic int ovr_exp(input int c);
    int k = 0;
    foreach (ovr_q[i]) if (ovr_q[i] <= c - 2) k++;
    return (k > 255) ? 255 : k;
  endfunction

  function automatic int frame_len(input int n);
    return 2 * D * n + D;
  endfunction

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_accept(input int n, input logic [23:0] p);
    exp_q.push_back('{cyc, n, p});
    model_free = cyc + frame_len(n) + 1;
  endtask

  task automatic issue(input logic [4:0] f, input logic [23:0] p);
    int n = (f > 5'd23) ? 24 : int'(f) + 1;
    model_tgl = ~model_tgl;
    bus0.cmd_word = {model_tgl, 2'($urandom), f, p};
    if (cyc >= model_free) model_accept(n, p);
    else ovr_q.push_back(cyc);
  endtask

  task automatic noise();
    bus0.cmd_word = {model_tgl, 7'($urandom), 24'($urandom)};
  endtask

  task automatic wait_idle(input int extra);
    while (cyc < model_free + extra) step(1);
  endtask

  // Monitor: decodes frames from sclk/sdo/cs_n and checks them against the scoreboard.
  int          busy_len, nrx, done_cnt;
  logic [23:0] rx;
  logic        prev_sclk, prev_cs, prev_sdo, chk_stat;
  frame_t      e;

  always @(negedge clk) begin
    if (reset) begin
      busy_len = 0; nrx = 0; rx = '0; done_cnt = 0;
      prev_sclk = 1'b0; prev_cs = 1'b1; prev_sdo = 1'b0; chk_stat = 1'b0;
    end else begin
      if (chk_stat) begin
        chk_stat = 1'b0;
        check("status_after_done", bus0.status,
              {done_cnt[0], 1'b0, 14'd0, 8'(ovr_exp(cyc)), 8'(done_cnt)});
        check("done_one_cycle", 32'(bus0.done), 32'd0);
      end
      check("busy_vs_cs_n", 32'(bus0.busy), 32'(!bus0.cs_n));
      if (bus0.cs_n) check("idle_lines", {30'd0, bus0.sclk, bus0.sdo}, 32'd0);
      if (!bus0.cs_n && prev_cs) begin
        if (exp_q.size() == 0) check("unexpected_frame", 32'd1, 32'd0);
        else check("frame_start_cycle", 32'(cyc), 32'(exp_q[0].t + 1));
      end
      if (bus0.busy) begin
        busy_len++;
        if (bus0.sclk && !prev_sclk) begin
          rx = {rx[22:0], bus0.sdo};
          nrx++;
        end
        if (bus0.sclk && prev_sclk) check("sdo_stable_high", 32'(bus0.sdo), 32'(prev_sdo));
      end
      if (bus0.done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("frame_bits_count", 32'(nrx), 32'(e.n));
          check("frame_bits", 32'(rx), 32'(e.p & 24'((32'd1 << e.n) - 1)));
          check("busy_length", 32'(busy_len), 32'(frame_len(e.n)));
        end
        done_cnt++;
        chk_stat = 1'b1;
        busy_len = 0; nrx = 0; rx = '0;
      end
      prev_sclk = bus0.sclk;
      prev_cs   = bus0.cs_n;
      prev_sdo  = bus0.sdo;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, h;
    reset = 1'b1;
    bus0.cmd_word = '0;
    bus1.cmd_word = '0;
    step(3);
    check("reset_outputs", {27'd0, bus0.sclk, bus0.sdo, bus0.cs_n, bus0.busy, bus0.done}, 32'h4);
    check("reset_status", bus0.status, 32'd0);
    reset = 1'b0;
    step(3);

    // Basic frame: 0x87_0000A5 -> 8 bits 10100101, busy 34 cycles.
    issue(5'd7, 24'h0000A5);
    wait_idle(2);
    check("basic_status", bus0.status, 32'h8000_0001);

    // Single overrun mid-frame leaves the frame intact.
    issue(5'd11, 24'($urandom));
    step(10);
    issue(5'd3, 24'($urandom));
    wait_idle(3);
    check("overrun_one", 32'(bus0.status[15:8]), 32'd1);

    // Back-to-back: next command lands exactly in the done cycle.
    issue(5'd4, 24'($urandom));
    while (cyc < model_free) step(1);
    issue(5'd5, 24'($urandom));
    wait_idle(3);
    check("b2b_count", 32'(bus0.status[7:0]), 32'd4);

    // Clamp: length field 31 sends 24 ones.
    issue(5'd31, 24'hFFFFFF);
    wait_idle(3);

    for (int i = 0; i < 40; i++) begin
      step($urandom_range(1, 40));
      if ($urandom_range(0, 3) == 0) noise();
      else issue(5'($urandom), 24'($urandom));
    end
    wait_idle(3);

    // Flip every cycle: overrun count must saturate.
    for (int i = 0; i < 300; i++) begin
      issue(5'd23, 24'($urandom));
      step(1);
    end
    wait_idle(3);
    check("overrun_saturate", 32'(bus0.status[15:8]), 32'd255);

    // Reset during bit 3 aborts the frame; held toggle=1 restarts on release.
    issue(5'd7, 24'($urandom));
    step(14);
    reset = 1'b1;
    #1;
    check("reset_mid_lines", {29'd0, bus0.cs_n, bus0.sclk, bus0.busy}, 32'h4);
    check("reset_mid_status", bus0.status, 32'd0);
    exp_q.delete();
    ovr_q.delete();
    model_free = 0;
    bus0.cmd_word = {1'b1, 2'b00, 5'd9, 24'h5A3C96};
    step(2);
    reset = 1'b0;
    model_tgl = 1'b1;
    model_accept(10, 24'h5A3C96);
    wait_idle(3);

    // Minimum divider on the second instance.
    bus1.cmd_word = {1'b1, 2'b00, 5'd0, 24'h000001};
    b = 0;
    h = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus1.busy) b++;
      if (bus1.sclk) begin
        h++;
        check("min_div_sdo", 32'(bus1.sdo), 32'd1);
      end
    end
    check("min_div_busy", 32'(b), 32'd3);
    check("min_div_sclk", 32'(h), 32'd1);
    check("min_div_status", bus1.status, 32'h8000_0001);

    step(2);
    check("frames_outstanding", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
